spmv_job_ctrl: RTL and testbench
================================

// Module: spmv_job_ctrl
// PURPOSE
//  Parametrised job controller for the SpMV engine. Polls a mailbox word in SRAM A until a doorbell is set,
//  pulses the engine start, and hands both SRAM ports to the engine while it runs. Bounds the run with a
//  cycle timeout, then writes a status word back into the mailbox, which clears the doorbell.
//  Sits between the SRAM A/B ports and the SpMV ops engine.
// PARAMETERS
//  DATA_W     256  SRAM word width in bits; must be >= 64
//  ADDR_W     5    SRAM address width in bits
//  MBOX_ADDR  0    SRAM A address of the mailbox word
//  POLL_GAP   4    idle cycles between mailbox reads; must be >= 1
//  TIMEOUT_W  24   run-cycle counter width in bits; must be <= 24
//  TIMEOUT    2**TIMEOUT_W-1  RUN cycles before the job is aborted
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rstn         in   1       synchronous reset, active low
//  i_read_data_A  in   DATA_W  SRAM A read data, valid 1 cycle after address
//  i_read_data_B  in   DATA_W  SRAM B read data, valid 1 cycle after address
//  o_address_A    out  ADDR_W  SRAM A address
//  o_wr_en_A      out  1       SRAM A write enable
//  o_write_data_A out  DATA_W  SRAM A write data
//  o_address_B    out  ADDR_W  SRAM B address
//  o_wr_en_B      out  1       SRAM B write enable
//  o_write_data_B out  DATA_W  SRAM B write data
//  o_eng_start    out  1       one-cycle engine start pulse
//  o_eng_abort    out  1       one-cycle engine abort pulse, issued on timeout
//  i_eng_done     in   1       engine completion pulse
//  i_eng_addr_A   in   ADDR_W  engine SRAM A address
//  i_eng_addr_B   in   ADDR_W  engine SRAM B address
//  i_eng_wr_en_B  in   1       engine SRAM B write enable
//  i_eng_wdata_B  in   DATA_W  engine SRAM B write data
//  o_state        out  3       current FSM state encoding
//  o_busy         out  1       1 in START and RUN
//  o_done         out  1       one-cycle pulse in DONE
//  o_timeout      out  1       sticky; set on timeout, cleared at the next START
//  o_job_count    out  16      completed jobs (OK or timeout), wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: i_rstn==0 at a rising edge clears everything and puts the FSM in WAIT.
//   This applies in any state, including RUN; no writeback and no abort pulse are issued.
//   All outputs are 0; o_address_A = MBOX_ADDR, o_state = WAIT.
//  States and encodings: WAIT=0, POLL=1, CHECK=2, START=3, RUN=4, WB=5, DONE=6.
//   Unused encodings return to WAIT.
//  WAIT: gap counter runs for POLL_GAP cycles, then -> POLL.
//  POLL: o_address_A = MBOX_ADDR; always -> CHECK.
//  CHECK: samples i_read_data_A (the read issued in POLL).
//   If [31:0] == 32'd1 -> START; otherwise -> WAIT and the gap counter reloads.
//  START: o_eng_start = 1 for this single cycle; clears the run counter and o_timeout; -> RUN.
//  RUN: o_address_A = i_eng_addr_A. SRAM B port is driven from i_eng_addr_B, i_eng_wr_en_B, i_eng_wdata_B.
//   The run counter increments each cycle.
//   i_eng_done == 1 -> WB with status 8'h01 (OK).
//   Otherwise, when the counter reaches TIMEOUT-1: o_eng_abort = 1 that cycle, o_timeout set,
//   -> WB with status 8'h02 (TIMEOUT).
//   If i_eng_done and the timeout condition occur in the same cycle, done wins: OK status, no abort.
//  WB: o_address_A = MBOX_ADDR, o_wr_en_A = 1, o_write_data_A =
//   {zeros, cycles[23:0] in [63:40], status in [39:32], 32'h0 in [31:0]}.
//   cycles = run-counter value, zero-extended to 24 bits. The doorbell is cleared by this write. -> DONE.
//  DONE: o_done = 1 and o_job_count increments; -> WAIT.
//  Port defaults: outside RUN, o_wr_en_B = 0 and o_address_B = 0.
//   o_wr_en_A = 1 only in WB. o_write_data_A = 0 outside WB.
//  i_eng_done outside RUN is ignored.
//  Latency: minimum 3 cycles from the doorbell being visible in SRAM to o_eng_start (POLL, CHECK, START).
//   Worst case is POLL_GAP+3.
//  Run counter saturates at TIMEOUT and never wraps.
// TESTING
//  1. Mailbox = 1 at reset release, POLL_GAP=4 -> o_eng_start pulses exactly once, 7 cycles after reset release.
//  2. Engine done after 10 RUN cycles -> WB writes [39:32]=8'h01 and [63:40]=10 at MBOX_ADDR.
//     Then o_done pulses once and o_job_count = 1.
//  3. Engine never done, TIMEOUT=16 -> o_eng_abort pulses in RUN cycle 16.
//     Status 8'h02, o_timeout stays 1 until the next START.
//  4. Done and timeout in the same cycle -> status 8'h01, o_eng_abort stays 0.
//  5. Mailbox = 2, then = 0 -> repeated WAIT/POLL/CHECK loop; o_eng_start and o_wr_en_A never asserted.
//  6. i_rstn low for 1 cycle mid-RUN with i_eng_wr_en_B = 1 -> next cycle state WAIT, o_wr_en_B = 0,
//     no WB write, o_job_count = 0.

Source files
------------

// File: rtl/spmv_job_ctrl_if.sv
// SRAM A/B ports and SpMV engine handshake between the job controller and its neighbours.
// The master side is the job controller; the slave side is the SRAMs plus engine.
interface spmv_job_ctrl_if #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 5
);
   logic [DATA_W-1:0] i_read_data_A;
   logic [DATA_W-1:0] i_read_data_B;
   logic [ADDR_W-1:0] o_address_A;
   logic              o_wr_en_A;
   logic [DATA_W-1:0] o_write_data_A;
   logic [ADDR_W-1:0] o_address_B;
   logic              o_wr_en_B;
   logic [DATA_W-1:0] o_write_data_B;
   logic              o_eng_start;
   logic              o_eng_abort;
   logic              i_eng_done;
   logic [ADDR_W-1:0] i_eng_addr_A;
   logic [ADDR_W-1:0] i_eng_addr_B;
   logic              i_eng_wr_en_B;
   logic [DATA_W-1:0] i_eng_wdata_B;

   modport master (
      input  i_read_data_A, i_read_data_B, i_eng_done, i_eng_addr_A, i_eng_addr_B,
             i_eng_wr_en_B, i_eng_wdata_B,
      output o_address_A, o_wr_en_A, o_write_data_A, o_address_B, o_wr_en_B,
             o_write_data_B, o_eng_start, o_eng_abort
   );

   modport slave (
      output i_read_data_A, i_read_data_B, i_eng_done, i_eng_addr_A, i_eng_addr_B,
             i_eng_wr_en_B, i_eng_wdata_B,
      input  o_address_A, o_wr_en_A, o_write_data_A, o_address_B, o_wr_en_B,
             o_write_data_B, o_eng_start, o_eng_abort
   );
endinterface

// File: rtl/spmv_job_ctrl.sv
// SpMV job controller: polls a mailbox doorbell, runs the engine under a cycle timeout,
// then writes a status word back to the mailbox.
//
// state | meaning
// WAIT  | idle gap between mailbox polls
// POLL  | mailbox address presented on SRAM A
// CHECK | mailbox word returned; doorbell == 1 launches a job
// START | one-cycle engine start pulse, run counter cleared
// RUN   | engine owns SRAM A address and SRAM B port; watch done / timeout
// WB    | status word written to the mailbox (clears the doorbell)
// DONE  | one-cycle done pulse, job counter advances
module spmv_job_ctrl #(
   parameter int          DATA_W    = 256,
   parameter int          ADDR_W    = 5,
   parameter int          MBOX_ADDR = 0,
   parameter int          POLL_GAP  = 4,
   parameter int          TIMEOUT_W = 24,
   parameter int unsigned TIMEOUT   = 2**TIMEOUT_W - 1
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   spmv_job_ctrl_if.master     bus,
   output logic [2:0]          o_state,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_timeout,
   output logic [15:0]         o_job_count
);
   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_POLL  = 3'd1,
      S_CHECK = 3'd2,
      S_START = 3'd3,
      S_RUN   = 3'd4,
      S_WB    = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(POLL_GAP - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_SAT  = TIMEOUT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0]    MBOX     = ADDR_W'(MBOX_ADDR);

   state_t                 state;
   logic [GAP_W-1:0]       gap_cnt;
   logic [TIMEOUT_W-1:0]   run_cnt;
   logic [7:0]             status;
   logic                   hit_tmo;
   logic [DATA_W-1:0]      wb_word;
   logic                   unused_rd;

   assign unused_rd = ^{bus.i_read_data_A[DATA_W-1:32], bus.i_read_data_B};

   // done has priority over timeout in the same RUN cycle
   assign hit_tmo = (state == S_RUN) && !bus.i_eng_done && (run_cnt == TMO_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state       <= S_WAIT;
         gap_cnt     <= GAP_LOAD;
         run_cnt     <= '0;
         status      <= '0;
         o_timeout   <= 1'b0;
         o_job_count <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (gap_cnt == '0) state <= S_POLL;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            S_POLL: state <= S_CHECK;
            S_CHECK: begin
               if (bus.i_read_data_A[31:0] == 32'd1) begin
                  state <= S_START;
               end else begin
                  state   <= S_WAIT;
                  gap_cnt <= GAP_LOAD;
               end
            end
            S_START: begin
               run_cnt   <= '0;
               o_timeout <= 1'b0;
               state     <= S_RUN;
            end
            S_RUN: begin
               if (run_cnt != TMO_SAT) run_cnt <= run_cnt + 1'b1;
               if (bus.i_eng_done) begin
                  status <= 8'h01;
                  state  <= S_WB;
               end else if (hit_tmo) begin
                  status    <= 8'h02;
                  o_timeout <= 1'b1;
                  state     <= S_WB;
               end
            end
            S_WB: state <= S_DONE;
            S_DONE: begin
               o_job_count <= o_job_count + 16'd1;
               state       <= S_WAIT;
               gap_cnt     <= GAP_LOAD;
            end
            default: begin
               state   <= S_WAIT;
               gap_cnt <= GAP_LOAD;
            end
         endcase
      end
   end

   always_comb begin
      wb_word        = '0;
      wb_word[63:40] = 24'(run_cnt);
      wb_word[39:32] = status;
   end

   // SRAM/engine ports are decoded from the registered state; RUN passes the engine through
   assign bus.o_address_A    = (state == S_RUN) ? bus.i_eng_addr_A : MBOX;
   assign bus.o_wr_en_A      = (state == S_WB);
   assign bus.o_write_data_A = (state == S_WB) ? wb_word : '0;
   assign bus.o_address_B    = (state == S_RUN) ? bus.i_eng_addr_B : '0;
   assign bus.o_wr_en_B      = (state == S_RUN) && bus.i_eng_wr_en_B;
   assign bus.o_write_data_B = (state == S_RUN) ? bus.i_eng_wdata_B : '0;
   assign bus.o_eng_start    = (state == S_START);
   assign bus.o_eng_abort    = hit_tmo;

   assign o_state = state;
   assign o_busy  = (state == S_START) || (state == S_RUN);
   assign o_done  = (state == S_DONE);
endmodule

// File: tb/tb_spmv_job_ctrl.sv
// Directed bench for spmv_job_ctrl: expected events are queued by the stimulus and
// checked by a monitor as the DUT presents them.
module tb_spmv_job_ctrl;
   localparam int DW   = 256;
   localparam int AW   = 5;
   localparam int MBOX = 3;
   localparam int GAP  = 4;
   localparam int TW   = 5;
   localparam int TMO  = 16;

   localparam int EV_START = 0;
   localparam int EV_ABORT = 1;
   localparam int EV_WB    = 2;
   localparam int EV_DONE  = 3;

   typedef struct {
      int          kind;
      logic [DW-1:0] val;
   } ev_t;

   logic          clk;
   logic          rstn;
   logic [2:0]    o_state;
   logic          o_busy;
   logic          o_done;
   logic          o_timeout;
   logic [15:0]   o_job_count;
   logic          tb_we;
   logic [31:0]   tb_wdata;
   logic [DW-1:0] mem_a [0:(1<<AW)-1];
   ev_t           expq[$];
   int            n_checks;
   int            n_fail;

   spmv_job_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   spmv_job_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .MBOX_ADDR(MBOX), .POLL_GAP(GAP),
      .TIMEOUT_W(TW), .TIMEOUT(TMO)
   ) dut (
      .i_clk(clk), .i_rstn(rstn), .bus(bus), .o_state(o_state), .o_busy(o_busy),
      .o_done(o_done), .o_timeout(o_timeout), .o_job_count(o_job_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM A model with one-cycle read latency; the bench can poke the mailbox word
   always @(posedge clk) begin
      if (bus.o_wr_en_A)  mem_a[bus.o_address_A] <= bus.o_write_data_A;
      else if (tb_we)     mem_a[MBOX] <= DW'(tb_wdata);
      bus.i_read_data_A <= mem_a[bus.o_address_A];
   end

   function automatic logic [DW-1:0] wb_word(input int cyc, input logic [7:0] st);
      logic [DW-1:0] w;
      w        = '0;
      w[63:40] = cyc[23:0];
      w[39:32] = st;
      return w;
   endfunction

   function automatic ev_t mk(input int kind, input logic [DW-1:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      return e;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input int kind, input logic [DW-1:0] act, input string name);
      ev_t e;
      chk({name, "_expected"}, DW'(expq.size() != 0), DW'(1));
      if (expq.size() != 0) begin
         e = expq.pop_front();
         chk({name, "_kind"}, DW'(kind), DW'(e.kind));
         chk(name, act, e.val);
      end
   endtask

   task automatic mbox_write(input logic [31:0] v);
      @(negedge clk);
      tb_we    = 1'b1;
      tb_wdata = v;
      @(negedge clk);
      tb_we    = 1'b0;
   endtask

   task automatic wait_start(output int cyc);
      bit seen;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus.o_eng_start) seen = 1;
      end
      chk("start_seen", DW'(seen), DW'(1));
   endtask

   task automatic wait_done();
      bit seen;
      int n;
      seen = 0;
      n    = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         #1;
         n++;
         if (o_done) seen = 1;
      end
      chk("done_seen", DW'(seen), DW'(1));
      @(negedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      int k;
      int n_chk_state;
      bit any_act;
      n_checks = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      tb_we    = 1'b0;
      tb_wdata = '0;
      for (int i = 0; i < (1<<AW); i++) mem_a[i] = '0;
      bus.i_read_data_B = '0;
      bus.i_eng_done    = 1'b0;
      bus.i_eng_addr_A  = AW'(7);
      bus.i_eng_addr_B  = '0;
      bus.i_eng_wr_en_B = 1'b0;
      bus.i_eng_wdata_B = '0;

      fork
         forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
               if (bus.o_eng_start) pop_chk(EV_START, '0, "start");
               if (bus.o_eng_abort) pop_chk(EV_ABORT, '0, "abort");
               if (bus.o_wr_en_A) begin
                  chk("wb_addr", DW'(bus.o_address_A), DW'(MBOX));
                  pop_chk(EV_WB, bus.o_write_data_A, "wb_word");
               end
               if (o_done) pop_chk(EV_DONE, DW'(o_job_count), "done_count");
            end
         end
         begin
            #1_000_000;
            $display("FAIL watchdog: time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // reset with the doorbell already set; job 1 finishes after 10 RUN cycles
      mbox_write(32'd1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_state", DW'(o_state), DW'(0));
      chk("rst_addr_a", DW'(bus.o_address_A), DW'(MBOX));
      chk("rst_outputs", DW'({o_busy, o_done, o_timeout, bus.o_wr_en_A, bus.o_eng_start,
                              bus.o_eng_abort, bus.o_wr_en_B}), DW'(0));
      chk("rst_job_count", DW'(o_job_count), DW'(0));
      expq.push_back(mk(EV_START, '0));
      expq.push_back(mk(EV_WB, wb_word(10, 8'h01)));
      expq.push_back(mk(EV_DONE, DW'(0)));
      @(negedge clk);
      rstn = 1'b1;
      wait_start(cyc);
      chk("start_latency", DW'(cyc + 1), DW'(7));
      repeat (10) @(negedge clk);
      bus.i_eng_done = 1'b1;
      @(negedge clk);
      bus.i_eng_done = 1'b0;
      wait_done();
      chk("job_count_1", DW'(o_job_count), DW'(1));

      // job 2 never completes: abort in RUN cycle 16
      expq.push_back(mk(EV_START, '0));
      expq.push_back(mk(EV_ABORT, '0));
      expq.push_back(mk(EV_WB, wb_word(16, 8'h02)));
      expq.push_back(mk(EV_DONE, DW'(1)));
      mbox_write(32'd1);
      wait_start(cyc);
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         @(negedge clk);
         #1;
         if (bus.o_eng_abort) k = i;
      end
      chk("abort_cycle", DW'(k), DW'(16));
      wait_done();
      chk("timeout_sticky", DW'(o_timeout), DW'(1));
      chk("job_count_2", DW'(o_job_count), DW'(2));

      // job 3: done and timeout coincide, done wins
      expq.push_back(mk(EV_START, '0));
      expq.push_back(mk(EV_WB, wb_word(16, 8'h01)));
      expq.push_back(mk(EV_DONE, DW'(2)));
      mbox_write(32'd1);
      chk("timeout_held", DW'(o_timeout), DW'(1));
      wait_start(cyc);
      @(negedge clk);
      #1;
      chk("timeout_cleared", DW'(o_timeout), DW'(0));
      chk("busy_run", DW'(o_busy), DW'(1));
      repeat (15) @(negedge clk);
      bus.i_eng_done = 1'b1;
      #1;
      chk("no_abort_on_done", DW'(bus.o_eng_abort), DW'(0));
      @(negedge clk);
      bus.i_eng_done = 1'b0;
      wait_done();
      chk("timeout_ok_job", DW'(o_timeout), DW'(0));

      // non-doorbell mailbox values keep the poll loop spinning
      for (int pass = 0; pass < 2; pass++) begin
         mbox_write(pass == 0 ? 32'd2 : 32'd0);
         n_chk_state = 0;
         any_act     = 0;
         repeat (40) begin
            @(negedge clk);
            #1;
            if (o_state == 3'd2) n_chk_state++;
            if (bus.o_eng_start || bus.o_wr_en_A) any_act = 1;
         end
         chk("poll_loop", DW'(n_chk_state >= 5), DW'(1));
         chk("poll_idle", DW'(any_act), DW'(0));
      end

      // reset mid-RUN with the engine writing SRAM B
      expq.push_back(mk(EV_START, '0));
      mbox_write(32'd1);
      wait_start(cyc);
      bus.i_eng_wr_en_B = 1'b1;
      bus.i_eng_addr_B  = AW'(5);
      repeat (3) @(negedge clk);
      #1;
      chk("run_wr_en_b", DW'(bus.o_wr_en_B), DW'(1));
      chk("run_addr_b", DW'(bus.o_address_B), DW'(5));
      rstn     = 1'b0;
      tb_we    = 1'b1;
      tb_wdata = 32'd0;
      @(negedge clk);
      rstn  = 1'b1;
      tb_we = 1'b0;
      #1;
      chk("rst_run_state", DW'(o_state), DW'(0));
      chk("rst_run_wr_en_b", DW'(bus.o_wr_en_B), DW'(0));
      chk("rst_run_job_count", DW'(o_job_count), DW'(0));
      bus.i_eng_wr_en_B = 1'b0;
      repeat (30) @(negedge clk);
      #2;
      chk("queue_drained", DW'(expq.size()), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
